// File: rtl/four_digit_scanner.sv
// Time-multiplexes a 4-character message across a 4-digit common-anode display.
// New messages are staged and swapped in only at a frame boundary.
//
// phase    | meaning
// BLANK_PH | cnt < BLANK: all anodes off while char settles
// DRIVE_PH | cnt >= BLANK: anode of the selected digit driven low
module four_digit_scanner #(
  parameter int DIV_W = 4,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] msg,
  input  logic        msg_load,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        load_ack
);

  localparam logic [DIV_W-1:0] CNT_MAX = '1;
  localparam logic [DIV_W-1:0] BLANK_C = BLANK[DIV_W-1:0];

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      staging_q, staging_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic             load_ack_q, load_ack_d;
  logic             boundary;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd3;
      shadow_q     <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign boundary = (idx_q == 2'd0) && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = (cnt_q == CNT_MAX) ? idx_q - 2'd1 : idx_q;
    shadow_d     = shadow_q;
    staging_d    = staging_q;
    pending_d    = pending_q;
    frame_done_d = boundary;
    load_ack_d   = 1'b0;
    if (boundary) begin
      // A load on the boundary cycle itself bypasses staging so it is not a frame late.
      if (msg_load) begin
        shadow_d   = msg;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (pending_q) begin
        shadow_d   = staging_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (msg_load) begin
      staging_d = msg;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    char       = shadow_q[{idx_q, 2'b00} +: 4];
    an         = 4'b1111;
    if (cnt_q >= BLANK_C) an = ~(4'b0001 << idx_q);
    frame_done = frame_done_q;
    load_ack   = load_ack_q;
  end

endmodule

// File: tb/tb_four_digit_scanner.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a frame-level
// model of the message history; a negedge monitor pops and compares.
module tb_four_digit_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] msg = '0;
  logic        msg_load = 1'b0;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_ack;

  four_digit_scanner #(.DIV_W(4), .BLANK(2)) dut (
    .clk(clk), .reset(reset), .msg(msg), .msg_load(msg_load),
    .char(char), .an(an), .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  localparam int SLOT  = 16;
  localparam int FRAME = 64;
  localparam int BLANK = 2;

  typedef struct {
    int          t;
    logic [3:0]  an;
    logic [3:0]  ch;
    logic        fd;
    logic        ack;
  } exp_t;

  typedef struct {
    int          t;
    logic [15:0] m;
  } load_t;

  exp_t  expq[$];
  load_t loads[$];
  int    t;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    done = 0;

  // Message on display during frame f: the last load made before that frame began.
  function automatic logic [15:0] shown_msg(int f);
    logic [15:0] m = '0;
    foreach (loads[i]) if (loads[i].t < f * FRAME) m = loads[i].m;
    return m;
  endfunction

  function automatic exp_t predict(int tc);
    exp_t e;
    int cnt, digit, f;
    logic [15:0] m;
    cnt   = tc % SLOT;
    digit = 3 - ((tc / SLOT) % 4);
    f     = tc / FRAME;
    m     = shown_msg(f);
    e.t   = tc;
    e.an  = 4'b1111;
    if (cnt >= BLANK) e.an[digit] = 1'b0;
    e.ch  = m[4*digit +: 4];
    e.fd  = (tc > 0) && (tc % FRAME == 0);
    e.ack = 1'b0;
    if (e.fd)
      foreach (loads[i])
        if (loads[i].t >= tc - FRAME && loads[i].t < tc) e.ack = 1'b1;
    return e;
  endfunction

  task automatic step(input logic ld, input logic [15:0] m);
    load_t l;
    expq.push_back(predict(t));
    msg_load = ld;
    msg      = m;
    if (ld) begin
      l.t = t; l.m = m;
      loads.push_back(l);
    end
    @(posedge clk); #1;
    t++;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    reset    = 1'b0;
    msg_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.t = -1; e.an = 4'b1111; e.ch = 4'h0; e.fd = 1'b0; e.ack = 1'b0;
      expq.push_back(e);
      @(posedge clk); #1;
    end
    loads.delete();
    t     = 0;
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        n_cmp += 4;
        if (an !== e.an) begin
          n_bad++; $display("FAIL an t=%0d got %b want %b", e.t, an, e.an);
        end
        if (char !== e.ch) begin
          n_bad++; $display("FAIL char t=%0d got %h want %h", e.t, char, e.ch);
        end
        if (frame_done !== e.fd) begin
          n_bad++; $display("FAIL frame_done t=%0d got %b want %b", e.t, frame_done, e.fd);
        end
        if (load_ack !== e.ack) begin
          n_bad++; $display("FAIL load_ack t=%0d got %b want %b", e.t, load_ack, e.ack);
        end
      end
    end
  end

  initial begin : driver
    @(posedge clk); #1;
    do_reset(3);
    for (int i = 0; i < 200; i++) step(i == 5, 16'h1234);

    do_reset(2);
    for (int i = 0; i < 200; i++)
      step(i == 10 || i == 30, (i == 10) ? 16'hAAAA : 16'hBEEF);

    do_reset(2);
    for (int i = 0; i < 140; i++) step(i == 63, 16'hC0DE);
    do_reset(2);
    for (int i = 0; i < 200; i++) step(i == 64, 16'hC0DE);

    do_reset(2);
    for (int i = 0; i < 40; i++) step(i == 20, 16'h5555);
    do_reset(2);
    for (int i = 0; i < 200; i++) step(1'b0, 16'h0);

    do_reset(2);
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 29) == 0, 16'($urandom));

    // Loads clustered around boundaries, then a mid-frame reset.
    for (int i = 0; i < 400; i++)
      step(((t % FRAME) >= 61 || (t % FRAME) <= 2) && $urandom_range(0, 1) == 1,
           16'($urandom));
    for (int i = 0; i < 37; i++) step($urandom_range(0, 7) == 0, 16'($urandom));
    do_reset(1);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 19) == 0, 16'($urandom));

    @(negedge clk); #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d entries left want 0", expq.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
    end
  end

endmodule
